// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises MEM load/store and IF fetch requests onto an 8-bit RAM.
// Define MEMCTRL_IO_FULL_EN to stall IO-space store bytes on io_buffer_full_i.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ls_enable_i,
  input  logic              ls_wr_i,
  input  logic [2:0]        ls_funct3_i,
  input  logic [31:0]       ls_addr_i,
  input  logic [31:0]       ls_data_i,
  output logic              load_store_ready_o,
  output logic [31:0]       load_data_o,
  output logic              memctrl_off_o,
  input  logic              if_enable_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_ready_o,
  output logic [31:0]       inst_o,
`ifdef MEMCTRL_IO_FULL_EN
  input  logic              io_buffer_full_i,
`endif
  input  logic [7:0]        mem_din_i,
  output logic [7:0]        mem_dout_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LS,
    S_IF,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          n_q, n_d;
  logic                wr_q, wr_d;
  logic                is_if_q, is_if_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         data_q, data_d;

  logic [ADDR_W-1:0]   a_cur;
  logic [2:0]          ls_size;
  logic [1:0]          rd_byte;
  logic                hold;
  logic                unused_f3;

  assign unused_f3 = ls_funct3_i[2];
  assign a_cur     = addr_q + ADDR_W'(cnt_q);
  assign rd_byte   = 2'(cnt_q - 3'd1);

`ifdef MEMCTRL_IO_FULL_EN
  localparam logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h30000);
  assign hold = io_buffer_full_i && (a_cur >= IO_BASE);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    ls_size = 3'd4;
    unique case (ls_funct3_i[1:0])
      2'd0:    ls_size = 3'd1;
      2'd1:    ls_size = 3'd2;
      default: ls_size = 3'd4;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    wr_d       = wr_q;
    is_if_d    = is_if_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    mem_wr_o   = 1'b0;
    mem_a_o    = '0;
    mem_dout_o = 8'h00;

    unique case (state_q)
      S_IDLE: begin
        if (ls_enable_i) begin
          state_d = S_LS;
          is_if_d = 1'b0;
          wr_d    = ls_wr_i;
          n_d     = ls_size;
          addr_d  = ADDR_W'(ls_addr_i);
          wdata_d = ls_data_i;
          data_d  = '0;
          cnt_d   = 3'd0;
        end else if (if_enable_i) begin
          state_d = S_IF;
          is_if_d = 1'b1;
          wr_d    = 1'b0;
          n_d     = 3'd4;
          addr_d  = ADDR_W'(if_addr_i);
          data_d  = '0;
          cnt_d   = 3'd0;
        end
      end

      S_LS, S_IF: begin
        if (state_q == S_IF && !if_enable_i) begin
          // fetch flushed by IF: drop it without a ready pulse
          state_d = S_IDLE;
        end else if (wr_q) begin
          if (!hold) begin
            mem_wr_o   = 1'b1;
            mem_a_o    = a_cur;
            mem_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            cnt_d      = cnt_q + 3'd1;
            if (cnt_q == n_q - 3'd1)
              state_d = S_DONE;
          end
        end else begin
          // RAM answers one cycle after the address, so capture lags issue
          if (cnt_q < n_q)
            mem_a_o = a_cur;
          if (cnt_q != 3'd0)
            data_d[{rd_byte, 3'b000} +: 8] = mem_din_i;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == n_q)
            state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      n_q     <= 3'd0;
      wr_q    <= 1'b0;
      is_if_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      wr_q    <= wr_d;
      is_if_q <= is_if_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  assign load_store_ready_o = (state_q == S_DONE) && !is_if_q;
  assign if_ready_o         = (state_q == S_DONE) && is_if_q;
  assign load_data_o        = load_store_ready_o ? data_q : '0;
  assign inst_o             = if_ready_o ? data_q : '0;
  assign memctrl_off_o      = load_store_ready_o |
                              (~ls_enable_i & (state_q != S_LS));

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: vector table plus corner-case sequences for mem_ctrl,
// with a byte RAM model and an in-order completion scoreboard.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_enable, ls_wr;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr, ls_data;
  logic        ls_ready;
  logic [31:0] load_data;
  logic        off;
  logic        if_enable;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] inst;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
`ifdef MEMCTRL_IO_FULL_EN
  logic        io_full;
`endif

  logic       pl_we;
  logic [9:0] pl_a;
  logic [7:0] pl_d;
  logic [7:0] ram [0:1023];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          pl;
    logic [31:0] pre;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    bit          is_if;
    bit          chk_d;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vt[11];

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .ls_enable_i        (ls_enable),
    .ls_wr_i            (ls_wr),
    .ls_funct3_i        (ls_funct3),
    .ls_addr_i          (ls_addr),
    .ls_data_i          (ls_data),
    .load_store_ready_o (ls_ready),
    .load_data_o        (load_data),
    .memctrl_off_o      (off),
    .if_enable_i        (if_enable),
    .if_addr_i          (if_addr),
    .if_ready_o         (if_ready),
    .inst_o             (inst),
`ifdef MEMCTRL_IO_FULL_EN
    .io_buffer_full_i   (io_full),
`endif
    .mem_din_i          (mem_din),
    .mem_dout_o         (mem_dout),
    .mem_a_o            (mem_a),
    .mem_wr_o           (mem_wr)
  );

  // single-port byte RAM, read data one cycle after the address
  always @(posedge clk) begin
    if (pl_we) ram[pl_a] <= pl_d;
    else if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w,
                         input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      pl_we = 1'b1;
      pl_a  = 10'(a + 32'(k));
      pl_d  = w[8*k +: 8];
    end
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic sb_pop(input bit is_if, input int c, input logic [31:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_empty: unexpected completion (fetch=%0d) at cycle %0d",
               is_if, c);
      return;
    end
    e = sb.pop_front();
    chk("kind", 32'(is_if), 32'(e.is_if));
    chk("latency", 32'(c), 32'(e.lat));
    if (e.chk_d) chk("data", d, e.data);
  endtask

  task automatic wait_done(input int c0, input int nexp, input bit cb,
                           input logic [31:0] a0, input int n,
                           input bit wr, input logic [31:0] wd);
    int got;
    int c;
    got = 0;
    c = c0;
    while (got < nexp && c <= c0 + 40) begin
      @(negedge clk);
      if (cb && c <= n) begin
        chk("mem_a", mem_a, a0 + 32'(c - 1));
        chk("mem_wr", 32'(mem_wr), 32'(wr));
        if (wr) chk("mem_dout", 32'(mem_dout), 32'(wd[8*(c-1) +: 8]));
      end
      if (ls_ready) begin
        chk("off_at_ready", 32'(off), 32'd1);
        sb_pop(1'b0, c, load_data);
        ls_enable = 1'b0;
        got++;
      end else if (ls_enable) begin
        chk("off_busy", 32'(off), 32'd0);
      end
      if (if_ready) begin
        sb_pop(1'b1, c, inst);
        if_enable = 1'b0;
        got++;
      end
      c++;
    end
    if (got < nexp) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got %0d completions, expected %0d", got, nexp);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    n = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    if (v.pl) preload(v.addr, v.pre, n);
    sb.push_back('{is_if: 1'b0, chk_d: !v.wr, data: v.exp, lat: v.lat});
    ls_enable = 1'b1;
    ls_wr     = v.wr;
    ls_funct3 = v.f3;
    ls_addr   = v.addr;
    ls_data   = v.wdata;
    @(posedge clk);
    wait_done(1, 1, 1'b1, v.addr, n, v.wr, v.wdata);
    if (v.wr)
      for (int k = 0; k < n; k++)
        chk("ram_byte", 32'(ram[10'(v.addr + 32'(k))]),
            32'(v.wdata[8*k +: 8]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{0, 3'b010, 32'h100, 32'h0, 1, 32'h44332211, 32'h44332211, 6};
    vt[1]  = '{1, 3'b000, 32'h204, 32'hDEADBEAB, 0, 32'h0, 32'h0, 2};
    vt[2]  = '{0, 3'b001, 32'h10, 32'h0, 1, 32'h0000FF80, 32'h0000FF80, 4};
    vt[3]  = '{0, 3'b100, 32'h11, 32'h0, 0, 32'h0, 32'h000000FF, 3};
    vt[4]  = '{1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 32'h0, 32'h0, 5};
    vt[5]  = '{0, 3'b010, 32'h300, 32'h0, 0, 32'h0, 32'hCAFEF00D, 6};
    vt[6]  = '{1, 3'b001, 32'h302, 32'h12345678, 0, 32'h0, 32'h0, 3};
    vt[7]  = '{0, 3'b010, 32'h300, 32'h0, 0, 32'h0, 32'h5678F00D, 6};
    vt[8]  = '{0, 3'b011, 32'hFFFFFFFE, 32'h0, 1, 32'hA1B2C3D4, 32'hA1B2C3D4, 6};
    vt[9]  = '{0, 3'b101, 32'h302, 32'h0, 0, 32'h0, 32'h00005678, 4};
    vt[10] = '{1, 3'b011, 32'h3F0, 32'h89ABCDEF, 0, 32'h0, 32'h0, 5};

    rst = 1'b1;
    ls_enable = 1'b0; ls_wr = 1'b0; ls_funct3 = 3'b0;
    ls_addr = '0; ls_data = '0;
    if_enable = 1'b0; if_addr = '0;
    pl_we = 1'b0; pl_a = '0; pl_d = '0;
`ifdef MEMCTRL_IO_FULL_EN
    io_full = 1'b0;
`endif

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ls_ready), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_off_idle", 32'(off), 32'd1);
    ls_enable = 1'b1;
    #1 chk("rst_off_req", 32'(off), 32'd0);
    ls_enable = 1'b0;
    #1 chk("rst_off_noreq", 32'(off), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vt[i]);

    // plain fetch
    preload(32'h0, 32'h0DDBA11F, 4);
    sb.push_back('{is_if: 1'b1, chk_d: 1'b1, data: 32'h0DDBA11F, lat: 6});
    if_enable = 1'b1;
    if_addr   = 32'h0;
    @(posedge clk);
    wait_done(1, 1, 1'b1, 32'h0, 4, 1'b0, 32'h0);

    // fetch and store together: store wins, fetch accepted after DONE/IDLE
    sb.push_back('{is_if: 1'b0, chk_d: 1'b0, data: 32'h0, lat: 5});
    sb.push_back('{is_if: 1'b1, chk_d: 1'b1, data: 32'h0DDBA11F, lat: 12});
    ls_enable = 1'b1; ls_wr = 1'b1; ls_funct3 = 3'b010;
    ls_addr = 32'h8; ls_data = 32'h55AA55AA;
    if_enable = 1'b1; if_addr = 32'h0;
    @(posedge clk);
    wait_done(1, 2, 1'b1, 32'h8, 4, 1'b1, 32'h55AA55AA);

    // fetch flushed in cycle 3, controller idle again in cycle 4
    if_enable = 1'b1;
    if_addr   = 32'h40;
    @(posedge clk);
    @(negedge clk);
    chk("flush_a1", mem_a, 32'h40);
    @(negedge clk);
    chk("flush_a2", mem_a, 32'h41);
    @(posedge clk); #1;
    if_enable = 1'b0;
    @(negedge clk);
    chk("flush_if_ready", 32'(if_ready), 32'd0);
    chk("flush_mem_wr", 32'(mem_wr), 32'd0);
    @(posedge clk); #1;
    sb.push_back('{is_if: 1'b0, chk_d: 1'b1, data: 32'h44332211, lat: 6});
    ls_enable = 1'b1; ls_wr = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h100;
    @(posedge clk);
    wait_done(1, 1, 1'b1, 32'h100, 4, 1'b0, 32'h0);

    // ls_enable dropped mid-load: transaction still completes
    sb.push_back('{is_if: 1'b0, chk_d: 1'b1, data: 32'h44332211, lat: 6});
    ls_enable = 1'b1; ls_wr = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    ls_enable = 1'b0;
    #1 chk("off_ls_dropped", 32'(off), 32'd0);
    wait_done(2, 1, 1'b0, 32'h0, 0, 1'b0, 32'h0);

    // reset in cycle 2 of a word store
    preload(32'h380, 32'h0, 4);
    ls_enable = 1'b1; ls_wr = 1'b1; ls_funct3 = 3'b010;
    ls_addr = 32'h380; ls_data = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    chk("rst_sw_wr1", 32'(mem_wr), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    ls_enable = 1'b0;
    @(negedge clk);
    chk("rst_sw_wr2", 32'(mem_wr), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_wr", 32'(mem_wr), 32'd0);
    chk("abort_mem_a", mem_a, 32'd0);
    chk("abort_mem_dout", 32'(mem_dout), 32'd0);
    chk("abort_ready", 32'(ls_ready), 32'd0);
    chk("abort_load_data", load_data, 32'd0);
    chk("abort_off", 32'(off), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_ready", 32'({ls_ready, if_ready}), 32'd0);
    end
    @(posedge clk); #1;
    chk("abort_ram0", 32'(ram[10'h380]), 32'h44);
    chk("abort_ram1", 32'(ram[10'h381]), 32'h33);
    chk("abort_ram2", 32'(ram[10'h382]), 32'h00);

`ifdef MEMCTRL_IO_FULL_EN
    // IO store stalled by a full buffer for cycles 1-3
    sb.push_back('{is_if: 1'b0, chk_d: 1'b0, data: 32'h0, lat: 5});
    ls_enable = 1'b1; ls_wr = 1'b1; ls_funct3 = 3'b000;
    ls_addr = 32'h30000; ls_data = 32'hDEADBEAB;
    io_full = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("io_stall_wr", 32'(mem_wr), 32'd0);
    end
    @(posedge clk); #1;
    io_full = 1'b0;
    @(negedge clk);
    chk("io_resume_wr", 32'(mem_wr), 32'd1);
    chk("io_resume_a", mem_a, 32'h30000);
    chk("io_resume_dout", 32'(mem_dout), 32'hAB);
    wait_done(5, 1, 1'b0, 32'h0, 0, 1'b0, 32'h0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
